ex: RTL and testbench
=====================

EX -- requirements
Module: ex

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: aluop  input  `AluOpBus (8)  operation code from ID/EX register.
REQ-004 SHALL have port: alusel  input  `AluSelBus (3)  result class (NOP/LOGIC/SHIFT/ARITH/MUL/DIV).
REQ-005 SHALL have port: opv1  input  `RegBus (32)  operand 1.
REQ-006 SHALL have port: opv2  input  `RegBus (32)  operand 2.
REQ-007 SHALL have port: we  input  `RegAddrBus (5)  destination register address.
REQ-008 SHALL have port: wreg  input  1  destination write enable.
REQ-009 SHALL have port: wd_o  output  `RegAddrBus (5)  destination address to EX/MEM register.
REQ-010 SHALL have port: wreg_o  output  1  write enable to EX/MEM register.
REQ-011 SHALL have port: wdata_o  output  `RegBus (32)  result.
REQ-012 SHALL have port: stall_req  output  1  request to hold PC, IF/ID and ID/EX registers.

Function
REQ-013 SHALL compute LOGIC (AND/OR/XOR), SHIFT (SLL/SRL/SRA, amount opv2[4:0]), ARITH (ADD/SUB/SLT/SLTU) and MUL (MUL/MULH/MULHSU/MULHU) results combinationally, zero latency, stall_req=0.
REQ-014 SHALL wrap ADD/SUB modulo 2^32; SLT signed, SLTU unsigned, result 0 or 1.
REQ-015 SHALL form MUL results from 64-bit product: MUL low 32 bits; MULH signed x signed high; MULHSU signed opv1 x unsigned opv2 high; MULHU unsigned high.
REQ-016 SHALL execute DIV/DIVU/REM/REMU with an iterative restoring divider, one quotient bit per cycle.
REQ-017 Divider FSM states SHALL be IDLE, BUSY, DONE.
REQ-018 IDLE: on DIV-class op, latch operand magnitudes and signs, clear counter, go BUSY, or go DONE directly if divisor 0 or signed overflow; stall_req=1 combinationally.
REQ-019 BUSY: one iteration per cycle, stall_req=1; after 32nd iteration go DONE.
REQ-020 DONE: drive sign-corrected result on wdata_o, stall_req=0, go IDLE unconditionally next cycle (no restart on the still-present op).
REQ-021 Normal divide: op at cycle 0, stall_req high cycles 0-32, result valid with stall_req low at cycle 33.
REQ-022 Divide by zero: quotient 0xFFFFFFFF, remainder = opv1; stall one cycle, result at cycle 1.
REQ-023 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV 0x80000000, REM 0; stall one cycle.
REQ-024 Signed DIV quotient SHALL truncate toward zero; REM sign follows dividend.
REQ-025 Upstream SHALL hold inputs stable while stall_req=1; block SHALL not re-sample operands during BUSY.
REQ-026 Back-to-back DIV ops SHALL each run full sequence; second starts in IDLE the cycle after DONE.
REQ-027 wd_o = we and wreg_o = wreg pass through combinationally; alusel NOP or unknown SHALL give wdata_o=0.

Reset
REQ-028 While rst=1: wd_o=0, wreg_o=0, wdata_o=0, stall_req=0, FSM -> IDLE, counter and divider registers cleared.
REQ-029 rst asserted during BUSY SHALL abort division; no result emitted; first cycle after release is IDLE.

Structure
REQ-030 Op codes, alusel codes and bus widths SHALL live in shared defines.v (add EXE_MUL*/EXE_DIV*/EXE_REM* ops, EXE_RES_MUL, EXE_RES_DIV).
REQ-031 Divider SHALL be one sub-module, ex_div, with start/signed/opdata/result/ready handshake; FSM state codes local to it.

Verification
REQ-032 ADD 0x7FFFFFFF + 0x1 -> wdata_o 0x80000000 same cycle, stall_req 0.
REQ-033 MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE.
REQ-034 DIV -7 / 2 -> stall_req high 33 cycles, then wdata_o 0xFFFFFFFD; REM same -> 0xFFFFFFFF.
REQ-035 DIVU 5 / 0 -> one stall cycle, wdata_o 0xFFFFFFFF; REMU 5 / 0 -> 5.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> one stall cycle, 0x80000000.
REQ-037 rst pulsed at BUSY iteration 10, then DIVU 100 / 7 -> all outputs 0 during rst, fresh 33-cycle stall, 14.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared execute-stage definitions: bus widths, ALU op codes and result-class codes.
package ex_pkg;

  localparam int unsigned ALU_OP_W = 8;
  localparam int unsigned ALU_SEL_W = 3;
  localparam int unsigned REG_W = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [ALU_OP_W-1:0]   aluop_t;
  typedef logic [ALU_SEL_W-1:0]  alusel_t;
  typedef logic [REG_W-1:0]      word_t;
  typedef logic [REG_ADDR_W-1:0] regaddr_t;

  localparam aluop_t EXE_AND_OP    = 8'h24;
  localparam aluop_t EXE_OR_OP     = 8'h25;
  localparam aluop_t EXE_XOR_OP    = 8'h26;
  localparam aluop_t EXE_SLL_OP    = 8'h7C;
  localparam aluop_t EXE_SRL_OP    = 8'h02;
  localparam aluop_t EXE_SRA_OP    = 8'h03;
  localparam aluop_t EXE_ADD_OP    = 8'h20;
  localparam aluop_t EXE_SUB_OP    = 8'h22;
  localparam aluop_t EXE_SLT_OP    = 8'h2A;
  localparam aluop_t EXE_SLTU_OP   = 8'h2B;
  localparam aluop_t EXE_MUL_OP    = 8'h18;
  localparam aluop_t EXE_MULH_OP   = 8'h19;
  localparam aluop_t EXE_MULHSU_OP = 8'h1C;
  localparam aluop_t EXE_MULHU_OP  = 8'h1D;
  localparam aluop_t EXE_DIV_OP    = 8'h1A;
  localparam aluop_t EXE_DIVU_OP   = 8'h1B;
  localparam aluop_t EXE_REM_OP    = 8'h1E;
  localparam aluop_t EXE_REMU_OP   = 8'h1F;

  localparam alusel_t EXE_RES_NOP   = 3'b000;
  localparam alusel_t EXE_RES_LOGIC = 3'b001;
  localparam alusel_t EXE_RES_SHIFT = 3'b010;
  localparam alusel_t EXE_RES_ARITH = 3'b100;
  localparam alusel_t EXE_RES_MUL   = 3'b101;
  localparam alusel_t EXE_RES_DIV   = 3'b110;

  function automatic logic is_div_op(input aluop_t op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP) ||
           (op == EXE_REM_OP) || (op == EXE_REMU_OP);
  endfunction

endpackage

// File: rtl/ex_if.sv
// Handshake between the execute stage and its iterative divider.
interface ex_if
  import ex_pkg::*;
  ();
  logic             start;
  logic             sign;
  word_t            opdata1;
  word_t            opdata2;
  logic [2*REG_W-1:0] result;   // {remainder, quotient}
  logic             ready;
  logic             stall;

  modport master (output start, sign, opdata1, opdata2,
                  input  result, ready, stall);
  modport slave  (input  start, sign, opdata1, opdata2,
                  output result, ready, stall);
endinterface

// File: rtl/ex_div.sv
// Restoring divider, one quotient bit per cycle, on unsigned magnitudes with sign fix-up at the end.
module ex_div
  import ex_pkg::*;
(
  input logic clk,
  input logic rst,
  ex_if.slave div
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  word_t      quo_q, quo_d;
  word_t      rem_q, rem_d;
  word_t      dvs_q, dvs_d;
  logic       negq_q, negq_d;
  logic       negr_q, negr_d;

  logic        a_neg, b_neg, by_zero, overflow;
  word_t       a_mag, b_mag;
  logic [32:0] shifted, trial;

  always_comb begin
    a_neg    = div.sign & div.opdata1[31];
    b_neg    = div.sign & div.opdata2[31];
    a_mag    = a_neg ? -div.opdata1 : div.opdata1;
    b_mag    = b_neg ? -div.opdata2 : div.opdata2;
    by_zero  = (div.opdata2 == '0);
    overflow = div.sign && (div.opdata1 == 32'h8000_0000) && (div.opdata2 == '1);
    shifted  = {rem_q, quo_q[31]};
    trial    = shifted - {1'b0, dvs_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    div.stall = 1'b0;
    div.ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (div.start) begin
          div.stall = 1'b1;
          cnt_d     = '0;
          // Special cases store the final result directly and skip sign correction
          if (by_zero) begin
            quo_d   = '1;
            rem_d   = div.opdata1;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = DONE;
          end else if (overflow) begin
            quo_d   = 32'h8000_0000;
            rem_d   = '0;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = DONE;
          end else begin
            quo_d   = a_mag;
            rem_d   = '0;
            dvs_d   = b_mag;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        div.stall = 1'b1;
        if (!trial[32]) begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == '1) state_d = DONE;
      end
      DONE: begin
        div.ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div.result = {(negr_q ? -rem_q : rem_q), (negq_q ? -quo_q : quo_q)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

endmodule

// File: rtl/ex.sv
// Execute stage: single-cycle logic/shift/arith/mul results, multi-cycle divide with pipeline stall.
module ex
  import ex_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  aluop_t   aluop,
  input  alusel_t  alusel,
  input  word_t    opv1,
  input  word_t    opv2,
  input  regaddr_t we,
  input  logic     wreg,
  output regaddr_t wd_o,
  output logic     wreg_o,
  output word_t    wdata_o,
  output logic     stall_req
);

  ex_if div_bus ();

  ex_div u_div (
    .clk (clk),
    .rst (rst),
    .div (div_bus)
  );

  assign div_bus.start   = (alusel == EXE_RES_DIV) && is_div_op(aluop);
  assign div_bus.sign    = (aluop == EXE_DIV_OP) || (aluop == EXE_REM_OP);
  assign div_bus.opdata1 = opv1;
  assign div_bus.opdata2 = opv2;

  word_t       logic_res, shift_res, arith_res, mul_res, div_res, res;
  logic [4:0]  shamt;
  logic        mul_a_sx, mul_b_sx;
  logic [63:0] mul_a, mul_b, mul_p;

  always_comb begin
    shamt = opv2[4:0];

    logic_res = '0;
    case (aluop)
      EXE_AND_OP: logic_res = opv1 & opv2;
      EXE_OR_OP:  logic_res = opv1 | opv2;
      EXE_XOR_OP: logic_res = opv1 ^ opv2;
      default:    logic_res = '0;
    endcase

    shift_res = '0;
    case (aluop)
      EXE_SLL_OP: shift_res = opv1 << shamt;
      EXE_SRL_OP: shift_res = opv1 >> shamt;
      EXE_SRA_OP: shift_res = $unsigned($signed(opv1) >>> shamt);
      default:    shift_res = '0;
    endcase

    arith_res = '0;
    case (aluop)
      EXE_ADD_OP:  arith_res = opv1 + opv2;
      EXE_SUB_OP:  arith_res = opv1 - opv2;
      EXE_SLT_OP:  arith_res = {31'b0, $signed(opv1) < $signed(opv2)};
      EXE_SLTU_OP: arith_res = {31'b0, opv1 < opv2};
      default:     arith_res = '0;
    endcase

    // Sign-extending to 64 bits makes one unsigned multiply serve all signedness mixes
    mul_a_sx = (aluop == EXE_MULH_OP) || (aluop == EXE_MULHSU_OP);
    mul_b_sx = (aluop == EXE_MULH_OP);
    mul_a    = {{32{mul_a_sx & opv1[31]}}, opv1};
    mul_b    = {{32{mul_b_sx & opv2[31]}}, opv2};
    mul_p    = mul_a * mul_b;
    mul_res  = '0;
    case (aluop)
      EXE_MUL_OP:                              mul_res = mul_p[31:0];
      EXE_MULH_OP, EXE_MULHSU_OP, EXE_MULHU_OP: mul_res = mul_p[63:32];
      default:                                 mul_res = '0;
    endcase

    div_res = '0;
    if (div_bus.ready) begin
      if ((aluop == EXE_REM_OP) || (aluop == EXE_REMU_OP)) div_res = div_bus.result[63:32];
      else                                                 div_res = div_bus.result[31:0];
    end

    res = '0;
    case (alusel)
      EXE_RES_LOGIC: res = logic_res;
      EXE_RES_SHIFT: res = shift_res;
      EXE_RES_ARITH: res = arith_res;
      EXE_RES_MUL:   res = mul_res;
      EXE_RES_DIV:   res = div_res;
      default:       res = '0;
    endcase
  end

  assign wd_o      = rst ? '0   : we;
  assign wreg_o    = rst ? 1'b0 : wreg;
  assign wdata_o   = rst ? '0   : res;
  assign stall_req = rst ? 1'b0 : div_bus.stall;

endmodule

// File: tb/tb_ex.sv
// Directed bench for the execute stage: single-cycle ops, divider timing/results, reset abort.
module tb_ex;
  import ex_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  aluop_t   aluop;
  alusel_t  alusel;
  word_t    opv1, opv2;
  regaddr_t we;
  logic     wreg;
  regaddr_t wd_o;
  logic     wreg_o;
  word_t    wdata_o;
  logic     stall_req;

  always #5 clk = ~clk;

  ex dut (
    .clk       (clk),
    .rst       (rst),
    .aluop     (aluop),
    .alusel    (alusel),
    .opv1      (opv1),
    .opv2      (opv2),
    .we        (we),
    .wreg      (wreg),
    .wd_o      (wd_o),
    .wreg_o    (wreg_o),
    .wdata_o   (wdata_o),
    .stall_req (stall_req)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic set_op(input alusel_t s, input aluop_t o, input word_t a, input word_t b);
    alusel = s;
    aluop  = o;
    opv1   = a;
    opv2   = b;
  endtask

  task automatic comb_case(input string tag, input alusel_t s, input aluop_t o,
                           input word_t a, input word_t b, input word_t exp);
    set_op(s, o, a, b);
    @(negedge clk);
    check_eq(tag, wdata_o, exp);
    check_eq({tag, "_stall"}, {31'b0, stall_req}, 32'd0);
    @(posedge clk); #1;
  endtask

  // Entered just after a rising edge with a divide op on the inputs (cycle 0).
  task automatic div_case(input string tag, input int unsigned exp_cycles, input word_t exp_res);
    int unsigned n = 0;
    @(negedge clk);
    while (stall_req && n < 200) begin
      n++;
      @(negedge clk);
    end
    check_eq({tag, "_cycles"}, n, exp_cycles);
    check_eq(tag, wdata_o, exp_res);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    we   = 5'd9;
    wreg = 1'b1;
    set_op(EXE_RES_ARITH, EXE_ADD_OP, 32'd1, 32'd2);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_wd",    {27'b0, wd_o},      32'd0);
    check_eq("rst_wreg",  {31'b0, wreg_o},    32'd0);
    check_eq("rst_wdata", wdata_o,            32'd0);
    check_eq("rst_stall", {31'b0, stall_req}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    @(negedge clk);
    check_eq("pass_wd",   {27'b0, wd_o},   32'd9);
    check_eq("pass_wreg", {31'b0, wreg_o}, 32'd1);
    check_eq("add_small", wdata_o,         32'd3);
    @(posedge clk); #1;

    comb_case("and",    EXE_RES_LOGIC, EXE_AND_OP,    32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    comb_case("or",     EXE_RES_LOGIC, EXE_OR_OP,     32'hF0F0_0000, 32'h0F0F_1234, 32'hFFFF_1234);
    comb_case("xor",    EXE_RES_LOGIC, EXE_XOR_OP,    32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    comb_case("sll31",  EXE_RES_SHIFT, EXE_SLL_OP,    32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000);
    comb_case("srl",    EXE_RES_SHIFT, EXE_SRL_OP,    32'h8000_0000, 32'h0000_0024, 32'h0800_0000);
    comb_case("sra",    EXE_RES_SHIFT, EXE_SRA_OP,    32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
    comb_case("add_ov", EXE_RES_ARITH, EXE_ADD_OP,    32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    comb_case("sub_wr", EXE_RES_ARITH, EXE_SUB_OP,    32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
    comb_case("slt",    EXE_RES_ARITH, EXE_SLT_OP,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    comb_case("sltu",   EXE_RES_ARITH, EXE_SLTU_OP,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    comb_case("mul",    EXE_RES_MUL,   EXE_MUL_OP,    32'h0001_0000, 32'h0001_0003, 32'h0003_0000);
    comb_case("mulh",   EXE_RES_MUL,   EXE_MULH_OP,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    comb_case("mulhu",  EXE_RES_MUL,   EXE_MULHU_OP,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    comb_case("mulhsu", EXE_RES_MUL,   EXE_MULHSU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    comb_case("nop",    EXE_RES_NOP,   EXE_ADD_OP,    32'h0000_0001, 32'h0000_0002, 32'h0000_0000);
    comb_case("badsel", 3'b011,        EXE_ADD_OP,    32'h0000_0001, 32'h0000_0002, 32'h0000_0000);

    set_op(EXE_RES_DIV, EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2);
    div_case("div_m7_2", 33, 32'hFFFF_FFFD);
    set_op(EXE_RES_DIV, EXE_REM_OP, 32'hFFFF_FFF9, 32'd2);
    div_case("rem_m7_2", 33, 32'hFFFF_FFFF);
    set_op(EXE_RES_DIV, EXE_DIVU_OP, 32'd5, 32'd0);
    div_case("divu_5_0", 1, 32'hFFFF_FFFF);
    set_op(EXE_RES_DIV, EXE_REMU_OP, 32'd5, 32'd0);
    div_case("remu_5_0", 1, 32'd5);
    set_op(EXE_RES_DIV, EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF);
    div_case("div_ovf", 1, 32'h8000_0000);
    set_op(EXE_RES_DIV, EXE_REM_OP, 32'h8000_0000, 32'hFFFF_FFFF);
    div_case("rem_ovf", 1, 32'h0000_0000);

    set_op(EXE_RES_DIV, EXE_DIVU_OP, 32'd100, 32'd7);
    div_case("divu_b2b_1", 33, 32'd14);
    div_case("divu_b2b_2", 33, 32'd14);
    set_op(EXE_RES_DIV, EXE_REMU_OP, 32'd100, 32'd7);
    div_case("remu_100_7", 33, 32'd2);

    we   = 5'd7;
    wreg = 1'b1;
    set_op(EXE_RES_DIV, EXE_DIVU_OP, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("busy_stall", {31'b0, stall_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_wd",    {27'b0, wd_o},      32'd0);
    check_eq("abort_wreg",  {31'b0, wreg_o},    32'd0);
    check_eq("abort_wdata", wdata_o,            32'd0);
    check_eq("abort_stall", {31'b0, stall_req}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("abort_stall2", {31'b0, stall_req}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    div_case("divu_after_rst", 33, 32'd14);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
